// File: rtl/snoop_bus_ctrl.sv
// MSI snooping bus controller: round-robin arbitration over NUM_CORES L1 caches,
// a single snoop broadcast per transaction, then a fill from another cache or from dmem.
module snoop_bus_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 13,
  parameter int MEM_LAT   = 4,
  localparam int IDX_W    = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // Handshake: req_valid_i[c] is held high until done_o[c] pulses; grant_o stays
  // one-hot on the owner for the whole transaction, and drops the cycle after done.
  input  logic [NUM_CORES-1:0]          req_valid_i,
  input  logic [2*NUM_CORES-1:0]        req_op_i,
  input  logic [ADDR_W*NUM_CORES-1:0]   req_addr_i,
  output logic [NUM_CORES-1:0]          grant_o,
  output logic                          snoop_valid_o,
  output logic [ADDR_W-1:0]             snoop_addr_o,
  input  logic [NUM_CORES-1:0]          snoop_hit_i,
  input  logic [NUM_CORES-1:0]          snoop_dirty_i,
  output logic [NUM_CORES-1:0]          inv_o,
  output logic                          fill_src_o,
  output logic [IDX_W-1:0]              fill_owner_o,
  output logic                          mem_rd_o,
  output logic                          mem_wb_o,
  output logic [NUM_CORES-1:0]          done_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [2:0]                    state_dbg_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SNOOP    = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_XFER     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_UPG = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [1:0]           op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     src_idx_q, src_idx_d;
  logic                 err_q, err_d;

  logic [NUM_CORES-1:0] owner_oh;
  logic [NUM_CORES-1:0] oth_hit;
  logic [NUM_CORES-1:0] oth_dirty;
  logic                 multi_dirty;
  logic [IDX_W-1:0]     dirty_idx;
  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W:0]       cand;

  assign owner_oh    = {{(NUM_CORES-1){1'b0}}, 1'b1} << owner_q;
  // The owner's own snoop response is meaningless for coherence and is dropped.
  assign oth_hit     = snoop_hit_i & ~owner_oh;
  assign oth_dirty   = snoop_dirty_i & ~owner_oh;
  assign multi_dirty = (oth_dirty & (oth_dirty - 1'b1)) != '0;

  always_comb begin
    dirty_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (oth_dirty[i]) dirty_idx = IDX_W'(i);
    end
  end

  // First requester at or after rr_ptr_q, wrapping modulo NUM_CORES.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
      if (!arb_found && req_valid_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      src_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      src_idx_q <= src_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    op_d          = op_q;
    addr_d        = addr_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    src_idx_d     = src_idx_q;
    err_d         = err_q;
    snoop_valid_o = 1'b0;
    inv_o         = '0;
    fill_src_o    = 1'b0;
    fill_owner_o  = '0;
    mem_rd_o      = 1'b0;
    mem_wb_o      = 1'b0;
    done_o        = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          owner_d = arb_idx;
          op_d    = req_op_i[arb_idx*2 +: 2];
          addr_d  = req_addr_i[arb_idx*ADDR_W +: ADDR_W];
          state_d = S_SNOOP;
        end
      end
      S_SNOOP: begin
        snoop_valid_o = 1'b1;
        src_idx_d     = dirty_idx;
        cnt_d         = '0;
        if (op_q == OP_RSV || multi_dirty) err_d = 1'b1;
        case (op_q)
          OP_UPG: begin
            inv_o   = oth_hit;
            if (oth_dirty != '0) err_d = 1'b1;
            state_d = S_DONE;
          end
          OP_WR: begin
            if (oth_dirty != '0) begin
              state_d = S_XFER;
            end else begin
              inv_o   = oth_hit;
              state_d = S_MEM_WAIT;
            end
          end
          default: begin
            // Read miss, and the reserved op handled as a read miss.
            state_d = (oth_dirty != '0) ? S_XFER : S_MEM_WAIT;
          end
        endcase
      end
      S_MEM_WAIT: begin
        mem_rd_o = (cnt_q == '0);
        if (cnt_q == CNT_W'(MEM_LAT - 1)) state_d = S_DONE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      S_XFER: begin
        fill_src_o   = 1'b1;
        fill_owner_o = src_idx_q;
        mem_wb_o     = 1'b1;
        if (op_q == OP_WR) inv_o = ~owner_oh;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done_o   = owner_oh;
        rr_ptr_d = (owner_q == IDX_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = busy_o ? owner_oh : '0;
  assign snoop_addr_o = busy_o ? addr_q : '0;
  assign err_o        = err_q;
  assign state_dbg_o  = state_q;

endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
- Parametrised MSI snooping bus controller that replaces the fixed two-CPU bus arbiter.
- Serves NUM_CORES private L1 data caches on one shared bus with fair round-robin arbitration.
- Per transaction: one snoop broadcast, then cache-to-cache or dmem sourcing of the fill.
- Sits between the per-core cache controllers and the shared data memory; owns all coherence sequencing.

Parameters:
NUM_CORES, 4, number of cores/caches on the bus (2..8)
ADDR_W, 13, full byte address width
MEM_LAT, 4, dmem read latency in cycles (>=1)
IDX_W, $clog2(NUM_CORES), core index width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CORES  per-core request; held until matching done bit
req_op  in  2*NUM_CORES  per-core op: 00 read miss, 01 write miss, 10 upgrade (S->M invalidate), 11 reserved
req_addr  in  ADDR_W*NUM_CORES  per-core miss address
grant  out  NUM_CORES  one-hot current owner, held for whole transaction
snoop_valid  out  1  one-cycle snoop broadcast
snoop_addr  out  ADDR_W  address being snooped; valid whenever grant != 0
snoop_hit  in  NUM_CORES  core holds block S or M (sampled during snoop_valid)
snoop_dirty  in  NUM_CORES  core holds block M (sampled during snoop_valid)
inv  out  NUM_CORES  invalidate pulse to non-owner caches
fill_src  out  1  0 = dmem, 1 = other cache
fill_owner  out  IDX_W  index of supplying cache when fill_src=1
mem_rd  out  1  dmem read strobe (single cycle)
mem_wb  out  1  write dirty block back to dmem (single cycle)
done  out  NUM_CORES  one-cycle completion pulse to owner
busy  out  1  grant != 0
err  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE, rr_ptr=0, err=0; all other outputs 0 (snoop_addr 0).
- States: IDLE, SNOOP, MEM_WAIT, XFER, DONE.
- IDLE: if any req_valid, pick first requester at or after rr_ptr (wrapping modulo NUM_CORES). Latch winner index, op and addr; grant goes one-hot from next cycle -> SNOOP. No request -> stay IDLE.
- rr_ptr = winner+1 mod NUM_CORES, updated on leaving DONE.
- SNOOP (1 cycle): snoop_valid=1. Owner's own hit/dirty bits are masked. Capture others_hit, others_dirty.
- Read miss, a dirty other exists -> XFER: fill_src=1, fill_owner=dirty index, mem_wb=1 (dirty copy downgrades M->S in its cache).
- Read miss, no dirty other -> MEM_WAIT.
- Write miss, dirty other -> XFER: fill_src=1, mem_wb=1, inv to all non-owners.
- Write miss, clean -> MEM_WAIT; inv pulses in SNOOP cycle to all others with hit.
- Upgrade: inv to all other hit cores in SNOOP -> DONE; no data movement. Upgrade with others_dirty is a protocol error: err=1, still -> DONE.
- MEM_WAIT: mem_rd=1 in first cycle only; fill_src=0. Count MEM_LAT cycles, then -> DONE. Counter resets on entry.
- XFER: 1 cycle -> DONE.
- DONE: done[owner]=1 for 1 cycle; grant cleared next cycle -> IDLE. Back-to-back transactions have minimum 1 IDLE cycle.
- Latency (read, clean): grant to done = 1 + MEM_LAT + 1 cycles. Dirty: 3 cycles. Upgrade: 2 cycles.
- Boundaries:
  - >1 others_dirty, or op 11 -> err=1; op 11 treated as read miss.
  - Owner dropping req_valid mid-transaction is ignored; the transaction completes.
  - Simultaneous requests from all cores are served in rr order; no core waits more than NUM_CORES-1 transactions.
  - Async reset mid-transaction aborts immediately; no done is issued.
- err clears only on reset.

Test Plan:
- Core 2 read miss addr 0x0A4, no hits -> grant=0100, snoop_valid 1 cycle, mem_rd, done[2] after 6 cycles from grant, fill_src=0.
- Core 0 read miss, core 3 snoop_dirty -> fill_src=1, fill_owner=3, mem_wb=1, done[0] 3 cycles after grant.
- Core 1 upgrade, cores 0 and 2 hit -> inv=0101 in SNOOP cycle, done[1] 2 cycles after grant, no mem_rd/mem_wb.
- All four req_valid high continuously from reset -> grants in order 0,1,2,3,0; no core granted twice before others served.
- Cores 1 and 2 both snoop_dirty on core 0 read -> err=1 and stays 1 until rst_n low.
- rst_n asserted during MEM_WAIT -> all outputs 0 immediately, no done pulse, next grant goes to core 0.
